// File: rtl/trigger_input_conditioner_if.sv
// Trigger front-end bus: raw inputs and configuration in, conditioned
// triggers, timebase and event count out.
interface trigger_input_conditioner_if;
  logic [3:0]  trig_in;
  logic [5:0]  en_trigger;
  logic [7:0]  filter_len;
  logic        cnt_clr;
  logic        trigger_1;
  logic        trigger_2;
  logic        trigger_3;
  logic        trigger_4;
  logic        stime;
  logic [15:0] trig_count;

  modport master (
    output trig_in, en_trigger, filter_len, cnt_clr,
    input  trigger_1, trigger_2, trigger_3, trigger_4, stime, trig_count
  );

  modport slave (
    input  trig_in, en_trigger, filter_len, cnt_clr,
    output trigger_1, trigger_2, trigger_3, trigger_4, stime, trig_count
  );
endinterface

// File: rtl/trigger_input_conditioner.sv
// Trigger input conditioner: per-lane sync + glitch filter + gating,
// event counter over the OR of all lanes, and the stime timebase.

// One trigger lane: 2-flop synchroniser, polarity, glitch filter, output gate.
module trigger_input_conditioner_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  input  logic       inv,
  input  logic       en,
  input  logic       cfg_chg,
  input  logic [7:0] filter_len,
  output logic       trig
);
  logic       sync1, sync2, f;
  logic [7:0] cnt;
  logic       s2;

  assign s2 = sync2 ^ inv;

  // Synchronise, filter and gate; a config change restarts the filter from level 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      f     <= 1'b0;
      trig  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (cfg_chg) begin
        cnt  <= '0;
        f    <= 1'b0;
        trig <= 1'b0;
      end else begin
        if (s2 == f)
          cnt <= '0;
        else if (cnt >= filter_len) begin
          f   <= s2;
          cnt <= '0;
        end else
          cnt <= cnt + 8'd1;
        trig <= f & en;
      end
    end
  end
endmodule

module trigger_input_conditioner #(
  parameter int PRESCALE = 100,
  parameter int CNT_W    = 16
) (
  input logic clk,
  input logic rst,
  trigger_input_conditioner_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int PC_W      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);
  localparam logic [PC_W-1:0] PC_HALF = PC_W'(PRESCALE / 2);

  logic [5:0]           en_q;
  logic                 cfg_chg;
  logic [NUM_LANES-1:0] trig;
  logic                 any, any_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [PC_W-1:0]      pc;
  logic                 stime_q;

  assign cfg_chg = (bus.en_trigger != en_q);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    trigger_input_conditioner_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .raw        (bus.trig_in[i]),
      .inv        (bus.en_trigger[4]),
      .en         (bus.en_trigger[i] & bus.en_trigger[5]),
      .cfg_chg    (cfg_chg),
      .filter_len (bus.filter_len),
      .trig       (trig[i])
    );
  end

  // Registered copy of the configuration used to detect changes.
  always_ff @(posedge clk) begin
    if (rst) en_q <= '0;
    else     en_q <= bus.en_trigger;
  end

  assign any = |trig;

  // Count rising edges of the combined trigger, saturating; clear has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_d <= 1'b0;
      cnt_q <= '0;
    end else begin
      any_d <= any;
      if (bus.cnt_clr)
        cnt_q <= '0;
      else if (any && !any_d && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Timebase: high for the first half of each PRESCALE-cycle period.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      stime_q <= 1'b0;
    end else begin
      pc      <= (pc == PC_LAST) ? '0 : pc + 1'b1;
      stime_q <= (pc < PC_HALF);
    end
  end

  assign bus.trigger_1  = trig[0];
  assign bus.trigger_2  = trig[1];
  assign bus.trigger_3  = trig[2];
  assign bus.trigger_4  = trig[3];
  assign bus.stime      = stime_q;
  assign bus.trig_count = 16'(cnt_q);
endmodule

// File: tb/tb_trigger_input_conditioner.sv
// Directed bench for trigger_input_conditioner (default instance plus a
// PRESCALE=4 / 4-bit counter instance for short-period and saturation cases).
module tb_trigger_input_conditioner;
  logic clk = 1'b0;
  logic rst, rst2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  trigger_input_conditioner_if bus ();
  trigger_input_conditioner_if bus2 ();

  trigger_input_conditioner dut (.clk(clk), .rst(rst), .bus(bus));
  trigger_input_conditioner #(.PRESCALE(4), .CNT_W(4)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] trigs();
    return {bus.trigger_4, bus.trigger_3, bus.trigger_2, bus.trigger_1};
  endfunction

  // Drive channel ch away from its idle level for w cycles, observe span edges.
  task automatic pulse(input int ch, input logic idle, input int w, input int span,
                       output int first, output int width);
    logic [3:0] v;
    first = -1;
    width = 0;
    bus.trig_in[ch] = ~idle;
    for (int i = 0; i < span; i++) begin
      tick();
      if (i == w - 1) bus.trig_in[ch] = idle;
      v = trigs();
      if (v[ch]) begin
        width++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.trig_in = 4'hF; bus.en_trigger = 6'h2F; bus.filter_len = 8'd0; bus.cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({trigs(), bus.stime, bus.trig_count} !== 21'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d: trig=%h stime=%b count=%h expected 0", i, trigs(), bus.stime, bus.trig_count);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (trigs() !== 4'h0) begin errors++; $display("FAIL reset_early_edge%0d: trig=%h expected 0", i, trigs()); end
    end
    tick();
    checks++;
    if (trigs() !== 4'hF) begin errors++; $display("FAIL reset_edge3: trig=%h expected f", trigs()); end
    checks++;
    if (bus.trig_count !== 16'd0) begin errors++; $display("FAIL reset_count_edge3: count=%0d expected 0", bus.trig_count); end
    tick();
    checks++;
    if (bus.trig_count !== 16'd1) begin errors++; $display("FAIL reset_count_edge4: count=%0d expected 1", bus.trig_count); end
  endtask

  task automatic test_glitch();
    int first, width;
    bus.trig_in = 4'h0; bus.en_trigger = 6'h21; bus.filter_len = 8'd10;
    repeat (30) tick();
    checks++;
    if (trigs() !== 4'h0) begin errors++; $display("FAIL glitch_idle: trig=%h expected 0", trigs()); end
    pulse(0, 1'b0, 10, 40, first, width);
    checks++;
    if (width !== 0) begin errors++; $display("FAIL glitch_w10: high cycles=%0d expected 0", width); end
    pulse(0, 1'b0, 11, 40, first, width);
    checks++;
    if (width !== 11) begin errors++; $display("FAIL glitch_w11_width: high cycles=%0d expected 11", width); end
    checks++;
    if (first !== 13) begin errors++; $display("FAIL glitch_w11_latency: rise at %0d expected 13", first); end
    pulse(0, 1'b0, 60, 90, first, width);
    checks++;
    if (width !== 60) begin errors++; $display("FAIL glitch_w60_width: high cycles=%0d expected 60", width); end
  endtask

  task automatic test_polarity();
    int first, width;
    bus.trig_in = 4'h4; bus.en_trigger = 6'h34; bus.filter_len = 8'd2;
    repeat (20) tick();
    checks++;
    if (trigs() !== 4'h0) begin errors++; $display("FAIL pol_idle_high: trig=%h expected 0", trigs()); end
    pulse(2, 1'b1, 100, 130, first, width);
    checks++;
    if (width !== 100) begin errors++; $display("FAIL pol_width: high cycles=%0d expected 100", width); end
    checks++;
    if (first !== 5) begin errors++; $display("FAIL pol_latency: rise at %0d expected 5", first); end
    // Hold active, then drop master enable mid-pulse.
    bus.trig_in[2] = 1'b0;
    repeat (10) tick();
    checks++;
    if (trigs() !== 4'h4) begin errors++; $display("FAIL pol_held: trig=%h expected 4", trigs()); end
    bus.en_trigger = 6'h14;
    tick();
    checks++;
    if (trigs() !== 4'h0) begin errors++; $display("FAIL master_off: trig=%h expected 0", trigs()); end
    bus.en_trigger = 6'h34;
    repeat (4) tick();
    checks++;
    if (trigs() !== 4'h0) begin errors++; $display("FAIL restart_early: trig=%h expected 0", trigs()); end
    tick();
    checks++;
    if (trigs() !== 4'h4) begin errors++; $display("FAIL restart_requalify: trig=%h expected 4", trigs()); end
    bus.trig_in[2] = 1'b1;
    repeat (20) tick();
  endtask

  task automatic test_counter();
    bus.trig_in = 4'h0; bus.en_trigger = 6'h23; bus.filter_len = 8'd0;
    repeat (10) tick();
    bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
    checks++;
    if (bus.trig_count !== 16'd0) begin errors++; $display("FAIL cnt_clear: count=%0d expected 0", bus.trig_count); end
    for (int p = 0; p < 3; p++) begin
      bus.trig_in[0] = 1'b1; repeat (2) tick();
      bus.trig_in[1] = 1'b1; repeat (3) tick();
      bus.trig_in[0] = 1'b0; repeat (3) tick();
      bus.trig_in[1] = 1'b0; repeat (12) tick();
    end
    checks++;
    if (bus.trig_count !== 16'd3) begin errors++; $display("FAIL cnt_overlap: count=%0d expected 3", bus.trig_count); end
    // Clear lands on the same edge as an increment.
    bus.trig_in[0] = 1'b1;
    repeat (4) tick();
    bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
    checks++;
    if (bus.trig_count !== 16'd0) begin errors++; $display("FAIL cnt_clr_priority: count=%0d expected 0", bus.trig_count); end
    repeat (3) tick();
    checks++;
    if (bus.trig_count !== 16'd0) begin errors++; $display("FAIL cnt_clr_hold: count=%0d expected 0", bus.trig_count); end
    bus.trig_in[0] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_saturate();
    rst2 = 1'b1; tick();
    checks++;
    if ({bus2.stime, bus2.trig_count} !== 17'd0) begin
      errors++; $display("FAIL small_reset: stime=%b count=%0d expected 0", bus2.stime, bus2.trig_count);
    end
    rst2 = 1'b0;
    bus2.en_trigger = 6'h21; bus2.filter_len = 8'd0;
    repeat (5) tick();
    for (int p = 0; p < 14; p++) begin
      bus2.trig_in[0] = 1'b1; repeat (2) tick();
      bus2.trig_in[0] = 1'b0; repeat (2) tick();
    end
    repeat (6) tick();
    checks++;
    if (bus2.trig_count !== 16'd14) begin errors++; $display("FAIL sat_below: count=%0d expected 14", bus2.trig_count); end
    for (int p = 0; p < 3; p++) begin
      bus2.trig_in[0] = 1'b1; repeat (2) tick();
      bus2.trig_in[0] = 1'b0; repeat (2) tick();
    end
    repeat (6) tick();
    checks++;
    if (bus2.trig_count !== 16'd15) begin errors++; $display("FAIL sat_hold: count=%0d expected 15", bus2.trig_count); end
  endtask

  task automatic test_stime();
    logic [7:0] pat;
    logic       prev;
    int         run, trans;
    // Reset in the middle of an active trigger.
    bus.en_trigger = 6'h21; bus.filter_len = 8'd0; bus.trig_in = 4'h1;
    repeat (6) tick();
    checks++;
    if (bus.trigger_1 !== 1'b1) begin errors++; $display("FAIL pre_reset_trig: trigger_1=%b expected 1", bus.trigger_1); end
    rst = 1'b1; tick();
    checks++;
    if ({bus.trigger_1, bus.stime} !== 2'b00) begin
      errors++; $display("FAIL reset_midpulse: trigger_1=%b stime=%b expected 0 0", bus.trigger_1, bus.stime);
    end
    bus.trig_in = 4'h0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.stime !== 1'b1) begin errors++; $display("FAIL stime_first: stime=%b expected 1", bus.stime); end
    prev = bus.stime; run = 1; trans = 0;
    for (int i = 1; i < 10000; i++) begin
      tick();
      if (bus.stime === prev) run++;
      else begin
        checks++;
        if (run !== 50) begin errors++; $display("FAIL stime_run at %0d: len=%0d expected 50", i, run); end
        trans++; prev = bus.stime; run = 1;
      end
    end
    checks++;
    if (trans !== 199) begin errors++; $display("FAIL stime_transitions: %0d expected 199", trans); end
    // Short-period instance: 2 high, 2 low.
    rst2 = 1'b1; tick(); rst2 = 1'b0;
    pat = 8'b0011_0011;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus2.stime !== pat[i]) begin errors++; $display("FAIL stime_p4 cyc %0d: stime=%b expected %b", i, bus2.stime, pat[i]); end
    end
  endtask

  initial begin
    rst2 = 1'b1;
    bus2.trig_in = 4'h0; bus2.en_trigger = 6'h0; bus2.filter_len = 8'd0; bus2.cnt_clr = 1'b0;
    test_reset();
    test_glitch();
    test_polarity();
    test_counter();
    test_saturate();
    test_stime();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
